// File: rtl/storage_controller.sv
// Word-addressed SRAM below 0x8000, SPI-flash reads above it, plus a programmer passthrough mode.
// Define STORAGE_CONTROLLER_EXT_SPI_EN to build the flash read engine; otherwise external reads return 0.
module storage_controller (
   input  logic        clk,
   input  logic        rst,
   input  logic        memory_access,
   input  logic        memory_is_writing,
   input  logic [31:0] addr,
   input  logic [31:0] d_in,
   input  logic [3:0]  mem_be,
   input  logic        set_programming_mode,
   input  logic        external_storage_spi_miso,
   input  logic        programming_spi_cs_n,
   input  logic        programming_spi_sck,
   input  logic        programming_spi_mosi,
   output logic [31:0] d_out,
   output logic        out_valid,
   output logic        external_storage_spi_cs_n,
   output logic        external_storage_spi_sck,
   output logic        external_storage_spi_mosi,
   output logic        programming_spi_miso
);
   localparam int          DATA_W   = 32;
   localparam logic [31:0] EXT_BASE = 32'h0000_8000;
   localparam logic [7:0]  CMD_READ = 8'h03;

   logic [DATA_W-1:0] mem [0:8191];
   logic [12:0]       word_idx;
   logic              is_sram;
   logic              engine_idle;
   logic              req;
   logic [DATA_W-1:0] merged;
   logic              eng_cs_n, eng_sck, eng_mosi;
   logic              unused_addr_lsb;

   function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_w,
                                                     input logic [DATA_W-1:0] new_w,
                                                     input logic [3:0]        be);
      logic [DATA_W-1:0] r;
      for (int n = 0; n < 4; n++)
         r[8*n +: 8] = be[n] ? new_w[8*n +: 8] : old_w[8*n +: 8];
      return r;
   endfunction

   // Flash returns byte 0 first; it must land in the least significant lane.
   function automatic logic [DATA_W-1:0] byte_swap(input logic [DATA_W-1:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   assign word_idx        = addr[14:2];
   assign is_sram         = (addr < EXT_BASE);
   assign merged          = merge_lanes(mem[word_idx], d_in, mem_be);
   assign unused_addr_lsb = ^addr[1:0];
   assign req             = rst && memory_access && !set_programming_mode && engine_idle;

`ifdef STORAGE_CONTROLLER_EXT_SPI_EN
   typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_DONE} state_t;
   state_t            state_q, state_d;
   logic [5:0]        bit_cnt_q;
   logic [31:0]       tx_sh_q, rx_sh_q;
   logic              sck_q, cs_n_q, mosi_q;
   logic              flash_done;
   logic [DATA_W-1:0] flash_word;

   assign engine_idle = (state_q == S_IDLE);
   assign flash_done  = (state_q == S_DATA) && (state_d == S_DONE);
   assign flash_word  = byte_swap({rx_sh_q[30:0], external_storage_spi_miso});
   assign eng_cs_n    = cs_n_q;
   assign eng_sck     = sck_q;
   assign eng_mosi    = mosi_q;

   // A bit completes on the cycle sck falls (sck_q currently high).
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (req && !is_sram && !memory_is_writing) state_d = S_CMD;
         S_CMD:  if (sck_q && bit_cnt_q == 6'd7)  state_d = S_ADDR;
         S_ADDR: if (sck_q && bit_cnt_q == 6'd23) state_d = S_DATA;
         S_DATA: if (sck_q && bit_cnt_q == 6'd31) state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (set_programming_mode) state_d = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst || set_programming_mode) begin
         state_q   <= S_IDLE;
         cs_n_q    <= 1'b1;
         sck_q     <= 1'b0;
         mosi_q    <= 1'b0;
         bit_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: if (state_d == S_CMD) begin
               cs_n_q    <= 1'b0;
               sck_q     <= 1'b0;
               tx_sh_q   <= {CMD_READ, addr[23:0]};
               mosi_q    <= CMD_READ[7];
               bit_cnt_q <= '0;
            end
            S_CMD, S_ADDR, S_DATA: begin
               sck_q <= ~sck_q;
               if (sck_q) begin
                  tx_sh_q   <= tx_sh_q << 1;
                  mosi_q    <= tx_sh_q[30];
                  rx_sh_q   <= {rx_sh_q[30:0], external_storage_spi_miso};
                  bit_cnt_q <= (state_d != state_q) ? 6'd0 : bit_cnt_q + 6'd1;
                  if (state_d == S_DONE) cs_n_q <= 1'b1;
               end
            end
            default: begin
               cs_n_q <= 1'b1;
               sck_q  <= 1'b0;
               mosi_q <= 1'b0;
            end
         endcase
      end
   end
`else
   assign engine_idle = 1'b1;
   assign eng_cs_n    = 1'b1;
   assign eng_sck     = 1'b0;
   assign eng_mosi    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (req && is_sram && memory_is_writing) mem[word_idx] <= merged;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         d_out     <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (req) begin
            if (is_sram) begin
               d_out     <= memory_is_writing ? merged : mem[word_idx];
               out_valid <= 1'b1;
            end else if (memory_is_writing) begin
               out_valid <= 1'b1;
            end else begin
`ifndef STORAGE_CONTROLLER_EXT_SPI_EN
               d_out     <= '0;
               out_valid <= 1'b1;
`endif
            end
         end
`ifdef STORAGE_CONTROLLER_EXT_SPI_EN
         if (flash_done) begin
            d_out     <= flash_word;
            out_valid <= 1'b1;
         end
`endif
      end
   end

   assign external_storage_spi_cs_n = set_programming_mode ? programming_spi_cs_n : eng_cs_n;
   assign external_storage_spi_sck  = set_programming_mode ? programming_spi_sck  : eng_sck;
   assign external_storage_spi_mosi = set_programming_mode ? programming_spi_mosi : eng_mosi;
   assign programming_spi_miso      = set_programming_mode ? external_storage_spi_miso : 1'b0;

endmodule

// File: tb/tb_storage_controller.sv
// Bench for storage_controller: vector table for SRAM/control cases, directed sequences for SPI paths.
module tb_storage_controller;
   logic        clk = 1'b0;
   logic        rst;
   logic        memory_access, memory_is_writing;
   logic [31:0] addr, d_in;
   logic [3:0]  mem_be;
   logic        set_programming_mode;
   logic        external_storage_spi_miso;
   logic        programming_spi_cs_n, programming_spi_sck, programming_spi_mosi;
   logic [31:0] d_out;
   logic        out_valid;
   logic        external_storage_spi_cs_n, external_storage_spi_sck, external_storage_spi_mosi;
   logic        programming_spi_miso;
   logic        tb_miso;

   int checks = 0;
   int failures = 0;

   storage_controller dut (
      .clk(clk), .rst(rst),
      .memory_access(memory_access), .memory_is_writing(memory_is_writing),
      .addr(addr), .d_in(d_in), .mem_be(mem_be),
      .set_programming_mode(set_programming_mode),
      .external_storage_spi_miso(external_storage_spi_miso),
      .programming_spi_cs_n(programming_spi_cs_n),
      .programming_spi_sck(programming_spi_sck),
      .programming_spi_mosi(programming_spi_mosi),
      .d_out(d_out), .out_valid(out_valid),
      .external_storage_spi_cs_n(external_storage_spi_cs_n),
      .external_storage_spi_sck(external_storage_spi_sck),
      .external_storage_spi_mosi(external_storage_spi_mosi),
      .programming_spi_miso(programming_spi_miso)
   );

   always #5 clk = ~clk;

   // SPI flash model, mode 0: captures 32 command/address bits, then streams fl_data MSB first.
   logic [31:0] fl_data = 32'h01020304;
   logic [31:0] fl_rx = 32'h0;
   int          fl_cnt = 0;
   logic        model_miso = 1'b0;

   always @(posedge external_storage_spi_sck or posedge external_storage_spi_cs_n) begin
      if (external_storage_spi_cs_n) fl_cnt = 0;
      else begin
         if (fl_cnt < 32) fl_rx = {fl_rx[30:0], external_storage_spi_mosi};
         fl_cnt = fl_cnt + 1;
      end
   end

   always @(negedge external_storage_spi_sck) begin
      if (!external_storage_spi_cs_n && fl_cnt >= 32 && fl_cnt < 64)
         model_miso = fl_data[63 - fl_cnt];
   end

   assign external_storage_spi_miso = set_programming_mode ? tb_miso : model_miso;

   typedef struct {
      logic        mode;
      logic        acc;
      logic        wr;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  be;
      logic        exp_v;
      logic [31:0] exp_d;
   } vec_t;
   vec_t vecs[$];

   function automatic void add_vec(input logic mode, input logic acc, input logic wr,
                                   input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                                   input logic exp_v, input logic [31:0] exp_d);
      vec_t v;
      v.mode = mode; v.acc = acc; v.wr = wr; v.a = a; v.d = d; v.be = be;
      v.exp_v = exp_v; v.exp_d = exp_d;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int   lat;
      int   pulses;
      logic got;

      rst = 1'b0; memory_access = 1'b0; memory_is_writing = 1'b0;
      addr = '0; d_in = '0; mem_be = '0; set_programming_mode = 1'b0;
      programming_spi_cs_n = 1'b1; programming_spi_sck = 1'b0; programming_spi_mosi = 1'b0;
      tb_miso = 1'b0;
      repeat (3) tick();
      check("rst_dout", d_out, 32'h0);
      check("rst_valid", out_valid, 1'b0);
      check("rst_cs_n", external_storage_spi_cs_n, 1'b1);
      check("rst_sck", external_storage_spi_sck, 1'b0);
      check("rst_mosi", external_storage_spi_mosi, 1'b0);
      rst = 1'b1;
      tick();

      set_programming_mode = 1'b1;
      for (int v = 0; v < 8; v++) begin
         {programming_spi_cs_n, programming_spi_sck, programming_spi_mosi} = 3'(v);
         #1;
         check($sformatf("pt_pins_%0d", v),
               {29'b0, external_storage_spi_cs_n, external_storage_spi_sck, external_storage_spi_mosi}, 32'(v));
      end
      tb_miso = 1'b0; #1;
      check("pt_miso0", programming_spi_miso, 1'b0);
      tb_miso = 1'b1; #1;
      check("pt_miso1", programming_spi_miso, 1'b1);
      programming_spi_cs_n = 1'b1; programming_spi_sck = 1'b0; programming_spi_mosi = 1'b0;
      set_programming_mode = 1'b0; #1;
      check("normal_prog_miso", programming_spi_miso, 1'b0);
      check("normal_cs_idle", external_storage_spi_cs_n, 1'b1);
      tick();

      //      mode  acc   wr    addr           d_in           be       v     d_out
      add_vec(1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'hAABBCCDD, 4'b1111, 1'b1, 32'hAABBCCDD);
      add_vec(1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'h11223344, 4'b0101, 1'b1, 32'hAA22CC44);
      add_vec(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,        4'b0000, 1'b1, 32'hAA22CC44);
      add_vec(1'b0, 1'b1, 1'b0, 32'h0000_0013, 32'h0,        4'b0000, 1'b1, 32'hAA22CC44);
      add_vec(1'b0, 1'b1, 1'b1, 32'h0000_7FFC, 32'hDEADBEEF, 4'b1111, 1'b1, 32'hDEADBEEF);
      add_vec(1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0,        4'b0000, 1'b0, 32'hDEADBEEF);
      add_vec(1'b0, 1'b1, 1'b0, 32'h0000_7FFC, 32'h0,        4'b0000, 1'b1, 32'hDEADBEEF);
      add_vec(1'b0, 1'b1, 1'b1, 32'h0000_0020, 32'h12345678, 4'b1111, 1'b1, 32'h12345678);
      add_vec(1'b0, 1'b1, 1'b1, 32'h0000_0020, 32'hFFFFFFFF, 4'b0000, 1'b1, 32'h12345678);
      add_vec(1'b0, 1'b1, 1'b1, 32'h0000_0020, 32'h9A000000, 4'b1000, 1'b1, 32'h9A345678);
      add_vec(1'b0, 1'b1, 1'b1, 32'h0000_8000, 32'h00000055, 4'b1111, 1'b1, 32'h9A345678);
      add_vec(1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0,        4'b0000, 1'b0, 32'h9A345678);
      add_vec(1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0,        4'b0000, 1'b0, 32'h9A345678);
`ifndef STORAGE_CONTROLLER_EXT_SPI_EN
      add_vec(1'b0, 1'b1, 1'b0, 32'h0000_8004, 32'h0,        4'b0000, 1'b1, 32'h00000000);
`endif
      add_vec(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,        4'b0000, 1'b1, 32'hAA22CC44);

      foreach (vecs[i]) begin
         set_programming_mode = vecs[i].mode;
         memory_access = vecs[i].acc; memory_is_writing = vecs[i].wr;
         addr = vecs[i].a; d_in = vecs[i].d; mem_be = vecs[i].be;
         tick();
         check($sformatf("vec%0d_valid", i), out_valid, vecs[i].exp_v);
         check($sformatf("vec%0d_dout", i), d_out, vecs[i].exp_d);
      end
      memory_access = 1'b0; set_programming_mode = 1'b0;
      tick();

      for (int i = 0; i < 8192; i++) begin
         memory_access = 1'b1; memory_is_writing = 1'b1;
         addr = 32'(i) << 2; d_in = 32'(i); mem_be = 4'hF;
         tick();
         memory_access = 1'b0;
         tick();
         memory_access = 1'b1; memory_is_writing = 1'b0;
         tick();
         memory_access = 1'b0;
         check("sweep_valid", out_valid, 1'b1);
         check("sweep_dout", d_out, 32'(i));
      end
      tick();

`ifdef STORAGE_CONTROLLER_EXT_SPI_EN
      memory_access = 1'b1; memory_is_writing = 1'b0; addr = 32'h0000_8000;
      lat = 0; got = 1'b0;
      while (!got && lat < 200) begin
         tick();
         lat++;
         if (out_valid) got = 1'b1;
      end
      memory_access = 1'b0;
      check("flash_valid_seen", got, 1'b1);
      check("flash_latency_le_140", (lat <= 140), 1'b1);
      check("flash_dout", d_out, 32'h04030201);
      check("flash_mosi_stream", fl_rx, 32'h03008000);
      check("flash_done_cs_high", external_storage_spi_cs_n, 1'b1);
      pulses = 0;
      repeat (6) begin
         tick();
         if (out_valid) pulses++;
      end
      check("flash_extra_valid", pulses, 0);
      check("flash_after_cs_high", external_storage_spi_cs_n, 1'b1);

      memory_access = 1'b1; addr = 32'h0000_8004;
      repeat (30) tick();
      check("abort_cs_low_before", external_storage_spi_cs_n, 1'b0);
      set_programming_mode = 1'b1;
      tick();
      set_programming_mode = 1'b0; memory_access = 1'b0; #1;
      check("abort_cs_released", external_storage_spi_cs_n, 1'b1);
      pulses = 0;
      repeat (150) begin
         tick();
         if (out_valid) pulses++;
      end
      check("abort_no_valid", pulses, 0);
      check("abort_dout_held", d_out, 32'h04030201);

      memory_access = 1'b1; addr = 32'h0000_8000;
      repeat (40) tick();
      check("midrst_cs_low_before", external_storage_spi_cs_n, 1'b0);
`endif
      rst = 1'b0; memory_access = 1'b0;
      tick();
      check("midrst_cs_n", external_storage_spi_cs_n, 1'b1);
      check("midrst_sck", external_storage_spi_sck, 1'b0);
      check("midrst_valid", out_valid, 1'b0);
      check("midrst_dout", d_out, 32'h0);
      rst = 1'b1;
      pulses = 0;
      repeat (150) begin
         tick();
         if (out_valid) pulses++;
      end
      check("midrst_no_valid", pulses, 0);
      memory_access = 1'b1; memory_is_writing = 1'b0; addr = 32'h0000_0040;
      tick();
      memory_access = 1'b0;
      check("post_rst_read_valid", out_valid, 1'b1);
      check("post_rst_read_dout", d_out, 32'h00000010);
      tick();
      check("post_rst_valid_drop", out_valid, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/storage_controller.md
STORAGE_CONTROLLER -- requirements
Module: storage_controller

Interface
REQ-001 Port list (name, direction, width, meaning); reset is synchronous and active-low, on one clock:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous active-low reset
- memory_access  in  1  request strobe
- memory_is_writing  in  1  1 = write, 0 = read
- addr  in  32  byte address
- d_in  in  32  write data
- mem_be  in  4  byte enables; bit n enables d_in[8n+7:8n]
- set_programming_mode  in  1  1 = SPI passthrough mode
- external_storage_spi_miso  in  1  flash data in
- programming_spi_cs_n / programming_spi_sck / programming_spi_mosi  in  1 each  external programmer SPI
- d_out  out  32  read data
- out_valid  out  1  one-cycle completion pulse
- external_storage_spi_cs_n / external_storage_spi_sck / external_storage_spi_mosi  out  1 each  flash SPI
- programming_spi_miso  out  1  data returned to programmer

Function
REQ-002 Passthrough mode (set_programming_mode=1) SHALL combinationally drive external_storage_spi_cs_n/sck/mosi from programming_spi_cs_n/sck/mosi, and programming_spi_miso from external_storage_spi_miso.
REQ-003 In normal mode, programming_spi_miso SHALL be 0; the flash SPI pins SHALL be driven by the internal SPI engine, idle values cs_n=1, sck=0, mosi=0.
REQ-004 Memory requests SHALL be ignored, with no out_valid, while set_programming_mode=1.
REQ-005 SRAM region is addr < 0x0000_8000: 8192 x 32-bit words, word index addr[14:2], addr[1:0] ignored.
REQ-006 SRAM write: on a clock edge with memory_access=1 and memory_is_writing=1, each lane with mem_be[n]=1 SHALL be written.
- d_out SHALL load the resulting merged word (write-through).
- out_valid SHALL pulse high the next cycle.
REQ-007 SRAM read: d_out SHALL be registered with the addressed word one cycle after the request edge, with out_valid pulsed that cycle.
REQ-008 d_out SHALL hold its last value when no access completes; out_valid SHALL be 0 except on completion cycles.
REQ-009 External region is addr >= 0x8000. A read SHALL start a flash transaction with states IDLE -> CMD -> ADDR -> DATA -> DONE -> IDLE:
- assert cs_n low; send command 0x03 then addr[23:0], MSB first.
- receive 32 bits: first byte into d_out[7:0], then [15:8], [23:16], [31:24]; bits within each byte MSB first.
- SPI mode 0, sck = clk/2: mosi changes while sck low, miso sampled on sck rise.
REQ-010 In DONE, cs_n SHALL go high and out_valid SHALL pulse for one cycle; total latency is at most 140 cycles.
REQ-011 The requester SHALL hold memory_access and addr stable until out_valid; requests arriving while busy SHALL be ignored.
REQ-012 A write to the external region SHALL perform no SPI activity and SHALL pulse out_valid next cycle with d_out unchanged.
REQ-013 Asserting set_programming_mode mid-transaction SHALL abort it: state returns to IDLE, no out_valid, cs_n released.

Reset
REQ-014 While rst=0 at a clock edge, the following SHALL be cleared: d_out=0, out_valid=0, FSM to IDLE, engine cs_n=1/sck=0/mosi=0. SRAM contents are not cleared.
REQ-015 Reset asserted mid-transaction SHALL abort it with no out_valid.

Configuration
REQ-016 Macro STORAGE_CONTROLLER_EXT_SPI_EN:
- defined: REQ-009..REQ-013 are implemented.
- undefined: no SPI engine; external-region reads return d_out=0 with out_valid next cycle; engine pins stay idle; passthrough (REQ-002) is unaffected.

Verification
REQ-017 Passthrough: mode=1; sweep {cs_n,sck,mosi} over 000..111 -> flash pins equal inputs the same cycle; miso 0 then 1 -> programming_spi_miso 0 then 1.
REQ-018 SRAM loop, i = 0..0x1FFF: write addr=i, d_in=i, be=F; idle one cycle; read addr=i -> d_out==i one cycle later, out_valid pulses.
REQ-019 Byte enables: write 0xAABBCCDD at 0x10 with be=F, then 0x11223344 with be=0101 -> read returns 0xAA22CC44.
REQ-020 Flash read (macro defined): read 0x8000 with a SPI flash model holding bytes 0x01,0x02,0x03,0x04 -> mosi shows 0x03,0x00,0x80,0x00; d_out=0x04030201; single out_valid; cs_n high afterwards.
REQ-021 Reset mid-flash-read -> cs_n=1, out_valid=0, d_out=0; a new SRAM read then completes normally.
